ddr_rd_burst_sched: RTL and testbench

Read-request scheduler that sits directly upstream of the AXI read master (`rd_start`/`rd_ready`/`rd_done` UI). It accepts one large read request (byte address plus total beat count) and splits it into AXI-legal bursts. Bursts are capped at `MAX_BURST` beats, never cross a 4 KB boundary, and are issued only when the downstream read-data FIFO has room for the whole burst. Exactly one burst is outstanding at a time.

---
 rtl/ddr_rd_burst_sched.sv | 84 ++++++++
 tb/tb_ddr_rd_burst_sched.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/ddr_rd_burst_sched.sv
// ddr_rd_burst_sched: splits one large read request into AXI-legal bursts (<= MAX_BURST beats, no 4 KB crossing, FIFO room required), one burst in flight
// Ports:
//   ACLK, ARESET            clock, asynchronous active-high reset
//   req_valid/req_ready     request handshake; req_addr (byte address), req_beats (total beats)
//   req_done                one-cycle pulse when the whole request has completed
//   busy                    high whenever a request is in progress
//   fifo_space              free entries in the downstream read-data FIFO
//   rd_start                one-cycle burst start; rd_burst_len / rd_start_addr describe the burst
//   rd_ready, rd_done       read master idle / burst complete pulse
module ddr_rd_burst_sched #(
   parameter int DATA_WIDTH      = 64,
   parameter int ADDR_WIDTH      = 29,
   parameter int BURST_LEN_WIDTH = 8,
   parameter int LEN_WIDTH       = 16,
   parameter int MAX_BURST       = 64,
   parameter int FIFO_CNT_WIDTH  = 10
) (
   input  logic                       ACLK,
   input  logic                       ARESET,
   input  logic                       req_valid,
   output logic                       req_ready,
   input  logic [ADDR_WIDTH-1:0]      req_addr,
   input  logic [LEN_WIDTH-1:0]       req_beats,
   output logic                       req_done,
   output logic                       busy,
   input  logic [FIFO_CNT_WIDTH-1:0]  fifo_space,
   output logic                       rd_start,
   output logic [BURST_LEN_WIDTH-1:0] rd_burst_len,
   output logic [ADDR_WIDTH-1:0]      rd_start_addr,
   input  logic                       rd_ready,
   input  logic                       rd_done
);
   localparam int BEAT_SHIFT = $clog2(DATA_WIDTH / 8);
   typedef enum logic [2:0] {IDLE, CALC, ISSUE, WAIT_DONE, DONE} state_t;
   state_t state, state_nxt;
   logic [ADDR_WIDTH-1:0] cur_addr;
   logic [LEN_WIDTH-1:0]  remain, cap, bnd, len_calc;
   logic                  fire;
   always_comb begin
      // beats left before the next 4 KB boundary: 1..512
      bnd       = LEN_WIDTH'(10'd512 - {1'b0, cur_addr[11:3]});
      cap       = remain < LEN_WIDTH'(MAX_BURST) ? remain : LEN_WIDTH'(MAX_BURST);
      len_calc  = cap < bnd ? cap : bnd;
      fire      = state == ISSUE && rd_ready && 32'(fifo_space) >= 32'(rd_burst_len);
      req_ready = state == IDLE;
      busy      = state != IDLE;
      req_done  = state == DONE;
      rd_start  = fire;
      state_nxt = state;
      unique case (state)
         IDLE:      if (req_valid) state_nxt = req_beats == '0 ? DONE : CALC;
         CALC:      state_nxt = ISSUE;
         ISSUE:     if (fire) state_nxt = WAIT_DONE;
         WAIT_DONE: if (rd_done) state_nxt = remain != '0 ? CALC : DONE;
         DONE:      state_nxt = IDLE;
         default:   state_nxt = IDLE;
      endcase
   end
   always_ff @(posedge ACLK or posedge ARESET)
      if (ARESET) state <= IDLE;
      else        state <= state_nxt;
   always_ff @(posedge ACLK or posedge ARESET) begin
      if (ARESET) begin
         cur_addr      <= '0;
         remain        <= '0;
         rd_burst_len  <= '0;
         rd_start_addr <= '0;
      end else begin
         if (state == IDLE && req_valid) begin
            cur_addr <= req_addr & ~ADDR_WIDTH'(7);
            remain   <= req_beats;
         end
         // burst descriptor is captured here so it is stable for the whole ISSUE stall
         if (state == CALC) begin
            rd_burst_len  <= BURST_LEN_WIDTH'(len_calc);
            rd_start_addr <= cur_addr;
         end
         if (fire) begin
            cur_addr <= cur_addr + (ADDR_WIDTH'(rd_burst_len) << BEAT_SHIFT);
            remain   <= remain - LEN_WIDTH'(rd_burst_len);
         end
      end
   end
endmodule

// File: tb/tb_ddr_rd_burst_sched.sv
// tb_ddr_rd_burst_sched: randomized scoreboard bench for ddr_rd_burst_sched with a read-master responder
module tb_ddr_rd_burst_sched;
   localparam int AW = 29;
   logic          ACLK = 0, ARESET;
   logic          req_valid, req_ready, req_done, busy, rd_start, rd_ready, rd_done;
   logic [AW-1:0] req_addr, rd_start_addr;
   logic [15:0]   req_beats;
   logic [9:0]    fifo_space;
   logic [7:0]    rd_burst_len;
   always #5 ACLK = ~ACLK;
   ddr_rd_burst_sched dut (
      .ACLK(ACLK), .ARESET(ARESET), .req_valid(req_valid), .req_ready(req_ready),
      .req_addr(req_addr), .req_beats(req_beats), .req_done(req_done), .busy(busy),
      .fifo_space(fifo_space), .rd_start(rd_start), .rd_burst_len(rd_burst_len),
      .rd_start_addr(rd_start_addr), .rd_ready(rd_ready), .rd_done(rd_done)
   );
   typedef struct {logic [AW-1:0] addr; int len;} burst_t;
   burst_t exp_q[$];
   bit     done_q[$];
   int passes = 0, total = 0, cyc = 0;
   int acc_cyc = 0, last_ev = 0, rdone_cyc = 0, start_cyc = 0, starts = 0, dones = 0, ready_chk_cyc = -1;
   int lat_lo = 0, lat_hi = 0, stray_req = 0, stray_ack = 0, lat, hold, exp_c;
   bit prev_start = 0, rnd_fifo = 0, z;
   burst_t b;
   always @(posedge ACLK) cyc <= cyc + 1;
   task automatic chk(input string name, input bit ok, input longint act, input longint exp);
      total++;
      if (ok) passes++;
      else $display("FAIL %s: got %0h required %0h (cycle %0d)", name, act, exp, cyc);
   endtask
   // reference: greedy split by remaining beats, 64-beat cap and 4 KB boundary, 8 bytes per beat
   task automatic push_model(input logic [AW-1:0] addr, input int beats);
      logic [AW-1:0] a = addr & ~29'h7;
      int r = beats, bnd, l;
      while (r > 0) begin
         bnd = (4096 - int'(a[11:0])) / 8;
         l = r;
         if (l > 64) l = 64;
         if (l > bnd) l = bnd;
         exp_q.push_back('{a, l});
         a = a + AW'(l * 8);
         r -= l;
      end
      done_q.push_back(beats == 0);
   endtask
   // monitor / scoreboard
   always @(negedge ACLK) begin
      if (ARESET) prev_start = 0;
      else begin
         if (req_valid && req_ready) begin acc_cyc = cyc; last_ev = cyc; end
         if (rd_done && busy) begin rdone_cyc = cyc; last_ev = cyc; end
         if (cyc == ready_chk_cyc) chk("req_ready_after_done", req_ready == 1, req_ready, 1);
         if (rd_start) begin
            chk("rd_start_back_to_back", !prev_start, prev_start, 0);
            chk("rd_start_rd_ready", rd_ready == 1, rd_ready, 1);
            chk("rd_start_fifo_space", int'(fifo_space) >= int'(rd_burst_len), fifo_space, rd_burst_len);
            chk("rd_start_latency", cyc >= last_ev + 2, cyc - last_ev, 2);
            if (exp_q.size() == 0) chk("unexpected_rd_start", 0, rd_start_addr, 0);
            else begin
               b = exp_q.pop_front();
               chk("burst_addr", rd_start_addr == b.addr, rd_start_addr, b.addr);
               chk("burst_len", int'(rd_burst_len) == b.len, rd_burst_len, b.len);
            end
            start_cyc = cyc;
            starts++;
         end
         prev_start = rd_start;
         if (req_done) begin
            if (done_q.size() == 0) chk("unexpected_req_done", 0, 1, 0);
            else begin
               z = done_q.pop_front();
               exp_c = z ? acc_cyc + 1 : rdone_cyc + 1;
               chk("req_done_timing", cyc == exp_c, cyc, exp_c);
               chk("bursts_left_at_done", exp_q.size() == 0, exp_q.size(), 0);
            end
            ready_chk_cyc = cyc + 1;
            dones++;
         end
      end
   end
   // read master: drops rd_ready on rd_start, pulses rd_done after a latency, then idles again
   initial begin
      rd_ready = 1;
      rd_done = 0;
      forever begin
         @(negedge ACLK);
         if (rd_start) begin
            lat = $urandom_range(lat_lo, lat_hi);
            hold = $urandom_range(0, lat_hi - lat_lo);
            @(posedge ACLK); #1 rd_ready = 0;
            repeat (lat) @(posedge ACLK);
            #1 rd_done = 1;
            @(posedge ACLK); #1 rd_done = 0;
            repeat (hold) @(posedge ACLK);
            #1 rd_ready = 1;
         end else if (stray_req != stray_ack) begin
            @(posedge ACLK); #1 rd_done = 1;
            @(posedge ACLK); #1 rd_done = 0;
            stray_ack = stray_req;
         end
      end
   end
   task automatic cycle();
      @(posedge ACLK); #1;
      if (rnd_fifo) fifo_space = 10'($urandom_range(0, 100));
   endtask
   task automatic do_req(input logic [AW-1:0] a, input int n);
      push_model(a, n);
      req_addr = a;
      req_beats = 16'(n);
      req_valid = 1;
      @(posedge ACLK); #1 req_valid = 0;
   endtask
   task automatic wait_done(input int budget);
      int k = 0;
      while (done_q.size() != 0 && k < budget) begin cycle(); k++; end
      if (done_q.size() != 0) begin
         chk("completion_timeout", 0, k, budget);
         exp_q.delete();
         done_q.delete();
      end
      cycle();
      cycle();
   endtask
   initial begin
      int s0, d0, sc, k;
      logic [AW-1:0] ra;
      ARESET = 1; req_valid = 0; req_addr = '0; req_beats = '0; fifo_space = 10'd1023;
      repeat (2) @(posedge ACLK);
      #1;
      chk("reset_req_ready", req_ready == 1, req_ready, 1);
      chk("reset_busy", busy == 0, busy, 0);
      chk("reset_req_done", req_done == 0, req_done, 0);
      chk("reset_rd_start", rd_start == 0, rd_start, 0);
      chk("reset_burst_len", rd_burst_len == 0, rd_burst_len, 0);
      chk("reset_start_addr", rd_start_addr == 0, rd_start_addr, 0);
      ARESET = 0;
      cycle();
      s0 = starts; do_req(29'h0F80, 100); wait_done(500);
      chk("boundary_split_bursts", starts - s0 == 3, starts - s0, 3);
      s0 = starts; do_req(29'h0100, 5); wait_done(100);
      chk("small_burst_latency", start_cyc - acc_cyc == 2, start_cyc - acc_cyc, 2);
      chk("small_burst_len_held", rd_burst_len == 5, rd_burst_len, 5);
      chk("small_burst_count", starts - s0 == 1, starts - s0, 1);
      fifo_space = 10'd10;
      s0 = starts; do_req(29'h0, 16);
      repeat (20) cycle();
      chk("no_start_during_stall", starts == s0, starts - s0, 0);
      fifo_space = 10'd16; sc = cyc;
      wait_done(100);
      chk("start_when_space", start_cyc == sc, start_cyc, sc);
      fifo_space = 10'd1023;
      s0 = starts; do_req(29'h1FFF_FFC0, 16); wait_done(200);
      chk("wrap_bursts", starts - s0 == 2, starts - s0, 2);
      s0 = starts; do_req(29'h40, 0); wait_done(20);
      chk("zero_beats_no_start", starts == s0, starts - s0, 0);
      d0 = dones; stray_req++;
      repeat (4) cycle();
      chk("stray_rd_done_ready", req_ready == 1, req_ready, 1);
      chk("stray_rd_done_busy", busy == 0, busy, 0);
      chk("stray_rd_done_no_done", dones == d0, dones - d0, 0);
      lat_lo = 8; lat_hi = 8;
      s0 = starts; do_req(29'h200, 10);
      repeat (4) cycle();
      req_addr = 29'h3000; req_beats = 16'd7; req_valid = 1;
      cycle();
      chk("req_ready_while_busy", req_ready == 0, req_ready, 0);
      cycle();
      req_valid = 0;
      wait_done(200);
      chk("ignored_req_bursts", starts - s0 == 1, starts - s0, 1);
      lat_lo = 10; lat_hi = 10;
      s0 = starts; do_req(29'h400, 200);
      k = 0;
      while (starts == s0 && k < 50) begin cycle(); k++; end
      chk("reset_test_started", starts != s0, starts - s0, 1);
      cycle(); cycle();
      ARESET = 1;
      #1;
      chk("midreset_busy", busy == 0, busy, 0);
      chk("midreset_rd_start", rd_start == 0, rd_start, 0);
      chk("midreset_burst_len", rd_burst_len == 0, rd_burst_len, 0);
      chk("midreset_start_addr", rd_start_addr == 0, rd_start_addr, 0);
      chk("midreset_req_ready", req_ready == 1, req_ready, 1);
      exp_q.delete();
      done_q.delete();
      cycle(); cycle();
      ARESET = 0;
      k = 0;
      while (!rd_ready && k < 100) begin cycle(); k++; end
      chk("master_idle_after_reset", rd_ready == 1, rd_ready, 1);
      lat_lo = 0; lat_hi = 0;
      s0 = starts; do_req(29'h800, 20); wait_done(100);
      chk("post_reset_request", starts - s0 == 1, starts - s0, 1);
      lat_lo = 0; lat_hi = 4; rnd_fifo = 1;
      repeat (40) begin
         ra = AW'($urandom);
         case ($urandom_range(0, 3))
            0: ra = {ra[AW-1:12], 12'hF00 | ra[11:0]};
            1: ra = 29'h1FFF_F000 | ra[11:0];
            default: ;
         endcase
         do_req(ra, $urandom_range(0, 4) == 0 ? 0 : $urandom_range(1, 300));
         wait_done(3000);
      end
      rnd_fifo = 0;
      chk("scoreboard_drained", exp_q.size() == 0, exp_q.size(), 0);
      $display("%0d/%0d checks passed", passes, total);
      $finish;
   end
   initial begin
      #800000;
      $display("FAIL watchdog: bench did not finish, %0d/%0d checks passed", passes, total);
      $fatal(1);
   end
endmodule
